// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch run controller: FSM state encoding and field select values.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        ADJ   = 2'b11
    } state_t;

    localparam logic FIELD_SEC = 1'b0;
    localparam logic FIELD_MIN = 1'b1;

endpackage

// File: rtl/stopwatch_run_ctrl_btn_conditioner.sv
// Raw button/switch conditioner: 2-FF synchroniser, counter debounce and a registered
// one-cycle press pulse on each debounced rising edge.
module btn_conditioner #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic arst_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic          level_d;
    logic [CW-1:0] db_cnt;

    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            db_cnt  <= '0;
            level_o <= 1'b0;
            level_d <= 1'b0;
            press_o <= 1'b0;
        end else begin
            sync_p0 <= raw_i;
            sync_p1 <= sync_p0;
            // Any cycle agreeing with the stable level restarts the run of differing cycles.
            if (sync_p1 == level_o) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt  <= '0;
                level_o <= sync_p1;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            level_d <= level_o;
            press_o <= level_o & ~level_d;
        end
    end

endmodule

// File: rtl/stopwatch_run_ctrl.sv
// Run/pause/adjust sequencer: conditions the four board inputs and drives the
// count/adjust/clear enables and blink strobe for the stopwatch counter.
module stopwatch_run_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000,
    parameter int TICK_DIV  = 100_000_000,
    parameter int ADJ_DIV   = 50_000_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       arst_i,
    input  logic       btn_pause_i,
    input  logic       btn_reset_i,
    input  logic       btn_sel_i,
    input  logic       sw_adj_i,
    output logic       cnt_en_o,
    output logic       adj_en_o,
    output logic       adj_field_o,
    output logic       clr_o,
    output logic       blink_o,
    output logic [1:0] state_o
);

    localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int AW = (ADJ_DIV   > 1) ? $clog2(ADJ_DIV)   : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ADJ_LAST   = AW'(ADJ_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic pause_level, pause_press;
    logic rst_level,   rst_press;
    logic sel_level,   sel_press;
    logic adj_level,   adj_press;
    logic unused_cond;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [AW-1:0] adj_cnt;
    logic [BW-1:0] blink_cnt;

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_pause (
        .clk(clk), .arst_i(arst_i), .raw_i(btn_pause_i), .level_o(pause_level), .press_o(pause_press)
    );
    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_reset (
        .clk(clk), .arst_i(arst_i), .raw_i(btn_reset_i), .level_o(rst_level), .press_o(rst_press)
    );
    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_sel (
        .clk(clk), .arst_i(arst_i), .raw_i(btn_sel_i), .level_o(sel_level), .press_o(sel_press)
    );
    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_adj (
        .clk(clk), .arst_i(arst_i), .raw_i(sw_adj_i), .level_o(adj_level), .press_o(adj_press)
    );

    // Buttons act on presses, the adjust switch on its level; the rest is not needed.
    assign unused_cond = ^{pause_level, rst_level, sel_level, adj_press};

    assign state_o = state;

    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            adj_cnt     <= '0;
            blink_cnt   <= '0;
            cnt_en_o    <= 1'b0;
            adj_en_o    <= 1'b0;
            clr_o       <= 1'b0;
            blink_o     <= 1'b0;
            adj_field_o <= FIELD_SEC;
        end else begin
            cnt_en_o <= 1'b0;
            adj_en_o <= 1'b0;
            clr_o    <= 1'b0;

            // Tick divider holds in PAUSE so a resume keeps the sub-second phase.
            if (state == RUN) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt <= '0;
                    cnt_en_o <= 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end else if (state == IDLE) begin
                tick_cnt <= '0;
            end

            if (state == ADJ) begin
                if (adj_cnt == ADJ_LAST) begin
                    adj_cnt  <= '0;
                    adj_en_o <= 1'b1;
                end else begin
                    adj_cnt <= adj_cnt + 1'b1;
                end
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_o   <= ~blink_o;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end else begin
                blink_cnt <= '0;
                blink_o   <= 1'b0;
            end

            if (sel_press && state == ADJ) begin
                adj_field_o <= ~adj_field_o;
            end

            // Transition priority: adjust entry, adjust exit, reset, pause.
            if (adj_level && state != ADJ) begin
                state     <= ADJ;
                adj_cnt   <= '0;
                blink_cnt <= '0;
                blink_o   <= 1'b0;
            end else if (state == ADJ && !adj_level) begin
                state   <= PAUSE;
                blink_o <= 1'b0;
            end else if (rst_press) begin
                clr_o <= 1'b1;
                if (state != ADJ) begin
                    state    <= IDLE;
                    tick_cnt <= '0;
                    cnt_en_o <= 1'b0;
                end
            end else if (pause_press && state != ADJ) begin
                state <= (state == RUN) ? PAUSE : RUN;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_run_ctrl.sv
// Bench for stopwatch_run_ctrl: directed scenarios plus random button activity, every
// cycle compared against a rule-level reference model.
module tb_stopwatch_run_ctrl;
    import stopwatch_pkg::*;

    localparam int DB = 4;
    localparam int TD = 10;
    localparam int AD = 5;
    localparam int BD = 3;

    logic       clk;
    logic       arst_i;
    logic [3:0] raw;
    logic       cnt_en_o, adj_en_o, adj_field_o, clr_o, blink_o;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_errors = 0;

    stopwatch_run_ctrl #(.DB_CYCLES(DB), .TICK_DIV(TD), .ADJ_DIV(AD), .BLINK_DIV(BD)) dut (
        .clk(clk), .arst_i(arst_i),
        .btn_pause_i(raw[0]), .btn_reset_i(raw[1]), .btn_sel_i(raw[2]), .sw_adj_i(raw[3]),
        .cnt_en_o(cnt_en_o), .adj_en_o(adj_en_o), .adj_field_o(adj_field_o),
        .clr_o(clr_o), .blink_o(blink_o), .state_o(state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model. Button bits: 0 pause, 1 reset, 2 sel, 3 adjust switch.
    logic [3:0] m_s1, m_s2, m_lvl, m_rose, m_press;
    logic [3:0] m_hist[$];
    int         m_start[4];
    state_t     m_st;
    int         m_tick, m_adjc, m_blc;
    logic       e_cnt, e_adj, e_clr, e_blink, e_field;

    task automatic m_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rose = '0; m_press = '0;
        m_hist.delete();
        for (int b = 0; b < 4; b++) m_start[b] = 0;
        m_st = IDLE; m_tick = 0; m_adjc = 0; m_blc = 0;
        e_cnt = 0; e_adj = 0; e_clr = 0; e_blink = 0; e_field = FIELD_SEC;
    endtask

    task automatic model_step();
        int n;
        bit all_diff;
        e_cnt = 0; e_adj = 0; e_clr = 0;
        if (m_st == RUN) begin
            m_tick = (m_tick + 1) % TD;
            e_cnt  = (m_tick == 0);
        end else if (m_st == IDLE) begin
            m_tick = 0;
        end
        if (m_st == ADJ) begin
            m_adjc = (m_adjc + 1) % AD;
            e_adj  = (m_adjc == 0);
            m_blc  = (m_blc + 1) % BD;
            if (m_blc == 0) e_blink = ~e_blink;
        end else begin
            m_blc = 0; e_blink = 0;
        end
        if (m_press[2] && m_st == ADJ) e_field = ~e_field;
        if (m_lvl[3] && m_st != ADJ) begin
            m_st = ADJ; m_adjc = 0; m_blc = 0; e_blink = 0;
        end else if (m_st == ADJ && !m_lvl[3]) begin
            m_st = PAUSE; e_blink = 0;
        end else if (m_press[1]) begin
            e_clr = 1;
            if (m_st != ADJ) begin
                m_st = IDLE; m_tick = 0; e_cnt = 0;
            end
        end else if (m_press[0] && m_st != ADJ) begin
            m_st = (m_st == RUN) ? PAUSE : RUN;
        end
        // Debounce: level flips once the last DB synced samples since the previous flip all differ.
        m_press = m_rose;
        m_rose  = '0;
        m_hist.push_back(m_s2);
        n = m_hist.size();
        for (int b = 0; b < 4; b++) begin
            if (n - m_start[b] >= DB) begin
                all_diff = 1;
                for (int j = n - DB; j < n; j++)
                    if (m_hist[j][b] == m_lvl[b]) all_diff = 0;
                if (all_diff) begin
                    m_lvl[b]   = ~m_lvl[b];
                    m_start[b] = n;
                    m_rose[b]  = m_lvl[b];
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic cmp_all();
        chk("state",  state_o,     m_st);
        chk("cnt_en", cnt_en_o,    e_cnt);
        chk("adj_en", adj_en_o,    e_adj);
        chk("clr",    clr_o,       e_clr);
        chk("blink",  blink_o,     e_blink);
        chk("field",  adj_field_o, e_field);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (arst_i) m_reset();
        else model_step();
        #1;
        cmp_all();
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
        for (int k = 0; k < budget; k++) begin
            if (state_o == s) break;
            cycle();
        end
        chk(tag, state_o, s);
    endtask

    task automatic wait_tick(input int v, input string tag);
        bit hit = 0;
        for (int k = 0; k < 40; k++) begin
            if (m_tick == v && state_o == RUN) begin
                hit = 1;
                break;
            end
            cycle();
        end
        chk(tag, hit, 1);
    endtask

    int presses, press_at, pulses, clrs, k_hit, cnt_adj;
    int adj_t[$], blink_t[$];
    logic prev_blink;
    int last_adj, bad_gap, after_clr;
    bit clr_seen, run_after;

    initial begin
        raw = '0;
        arst_i = 1'b1;
        m_reset();
        #12;
        cmp_all();
        @(posedge clk); #1;
        arst_i = 1'b0;
        repeat (3) cycle();

        // Bouncy pause button, then held high.
        presses = 0; press_at = -1; pulses = 0;
        for (int i = 0; i < 10; i++) begin
            raw[0] = ~raw[0];
            repeat (2) cycle();
            if (dut.u_pause.press_o) presses++;
        end
        raw[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (dut.u_pause.press_o) begin
                presses++;
                if (press_at < 0) press_at = k;
            end
            if (cnt_en_o) pulses++;
        end
        chk("bounce_press_count", presses, 1);
        chk("bounce_press_latency", press_at, 7);
        chk("bounce_state_run", state_o, RUN);
        raw[0] = 1'b0;
        for (int k = 0; k < 13; k++) begin
            cycle();
            if (cnt_en_o) pulses++;
        end
        chk("run25_cnt_pulses", pulses, 2);

        // Pause with divider at 5, hold 30 cycles, resume.
        wait_tick(7, "pause_align");
        raw[0] = 1'b1;
        wait_state(PAUSE, 20, "pause_entry");
        raw[0] = 1'b0;
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (cnt_en_o) pulses++;
        end
        chk("pause_no_cnt", pulses, 0);
        raw[0] = 1'b1;
        wait_state(RUN, 20, "resume_entry");
        raw[0] = 1'b0;
        k_hit = -1;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (cnt_en_o) begin
                k_hit = k;
                break;
            end
        end
        chk("resume_phase", k_hit, 5);

        // Reset and pause pressed together in RUN.
        raw[1:0] = 2'b11;
        clrs = 0; after_clr = 0; clr_seen = 0; run_after = 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 12) raw[1:0] = 2'b00;
            cycle();
            if (clr_o) begin
                clrs++;
                clr_seen = 1;
                chk("clr_to_idle", state_o, IDLE);
            end else if (clr_seen) begin
                if (cnt_en_o) after_clr++;
                if (state_o == RUN) run_after = 1;
            end
        end
        chk("rst_pause_clr_count", clrs, 1);
        chk("rst_pause_state", state_o, IDLE);
        chk("rst_pause_no_run", run_after, 0);
        chk("rst_pause_no_cnt", after_clr, 0);

        // Adjust entry from RUN.
        raw[0] = 1'b1;
        wait_state(RUN, 20, "adj_pre_run");
        raw[0] = 1'b0;
        repeat (4) cycle();
        raw[3] = 1'b1;
        wait_state(ADJ, 20, "adj_entry");
        adj_t.delete(); blink_t.delete(); pulses = 0; prev_blink = blink_o;
        for (int k = 1; k <= 30; k++) begin
            cycle();
            if (adj_en_o) adj_t.push_back(k);
            if (blink_o != prev_blink) blink_t.push_back(k);
            prev_blink = blink_o;
            if (cnt_en_o) pulses++;
        end
        chk("adj_first", (adj_t.size() > 1) ? adj_t[0] : -1, 5);
        chk("adj_period", (adj_t.size() > 1) ? adj_t[1] - adj_t[0] : -1, 5);
        chk("adj_no_cnt", pulses, 0);
        chk("blink_first", (blink_t.size() > 1) ? blink_t[0] : -1, 3);
        chk("blink_half", (blink_t.size() > 1) ? blink_t[1] - blink_t[0] : -1, 3);
        raw[2] = 1'b1;
        repeat (12) cycle();
        raw[2] = 1'b0;
        repeat (8) cycle();
        chk("sel_field_min", adj_field_o, FIELD_MIN);
        raw[3] = 1'b0;
        wait_state(PAUSE, 20, "adj_exit");
        chk("adj_exit_blink", blink_o, 0);

        // Reset press inside ADJ.
        raw[3] = 1'b1;
        wait_state(ADJ, 20, "adj_reentry");
        clrs = 0; bad_gap = 0; last_adj = -1; cnt_adj = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 2) raw[1] = 1'b1;
            if (k == 16) raw[1] = 1'b0;
            cycle();
            if (clr_o) clrs++;
            if (adj_en_o) begin
                cnt_adj++;
                if (last_adj >= 0 && k - last_adj != 5) bad_gap++;
                last_adj = k;
            end
        end
        chk("adj_rst_clr_count", clrs, 1);
        chk("adj_rst_state", state_o, ADJ);
        chk("adj_rst_cadence", bad_gap, 0);
        chk("adj_rst_pulses", cnt_adj, 8);
        raw[3] = 1'b0;
        wait_state(PAUSE, 20, "adj_exit2");

        // Async reset mid-RUN with the divider at 7.
        raw[0] = 1'b1;
        wait_state(RUN, 20, "arst_pre_run");
        raw[0] = 1'b0;
        wait_tick(7, "arst_align");
        #2;
        arst_i = 1'b1;
        #1;
        m_reset();
        chk("arst_state", state_o, IDLE);
        chk("arst_outs", {cnt_en_o, adj_en_o, clr_o, blink_o}, 0);
        chk("arst_field", adj_field_o, FIELD_SEC);
        repeat (2) cycle();
        arst_i = 1'b0;
        repeat (3) cycle();
        raw[0] = 1'b1;
        wait_state(RUN, 20, "post_arst_run");
        raw[0] = 1'b0;
        k_hit = -1;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (cnt_en_o) begin
                k_hit = k;
                break;
            end
        end
        chk("post_arst_first_tick", k_hit, 10);

        // Random button activity with occasional asynchronous resets.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                int idx;
                idx = $urandom_range(0, 3);
                raw[idx] = ~raw[idx];
            end
            if ($urandom_range(0, 599) == 0) begin
                arst_i = 1'b1;
                #1;
                m_reset();
                cmp_all();
                cycle();
                arst_i = 1'b0;
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
